// File: rtl/alu_share_arbiter.sv
// ============================================================================
// Module   : alu_share_arbiter
// Brief    : Shares one combinational ALU between two valid/ready requesters
//            with registered operands/results and a per-requester response
//            channel. Round-robin by default; define ALU_ARB_FIXED_PRIO_EN
//            for fixed priority (requester 0 wins ties).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_share_arbiter #(
  parameter int WIDTH  = 32,
  parameter int FUNC_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_lhs,
  input  logic [WIDTH-1:0]  req0_rhs,
  input  logic [FUNC_W-1:0] req0_func,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [WIDTH-1:0]  rsp0_res,
  output logic              rsp0_zero,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_lhs,
  input  logic [WIDTH-1:0]  req1_rhs,
  input  logic [FUNC_W-1:0] req1_func,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [WIDTH-1:0]  rsp1_res,
  output logic              rsp1_zero,
  output logic [WIDTH-1:0]  alu_lhs,
  output logic [WIDTH-1:0]  alu_rhs,
  output logic [3:0]        alu_func,
  input  logic [WIDTH-1:0]  alu_res,
  input  logic              alu_zero
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_exec = 2'd1;
  localparam logic [1:0] c_st_resp = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [WIDTH-1:0]  r_lhs;
  logic [WIDTH-1:0]  r_rhs;
  logic [FUNC_W-1:0] r_func;
  logic              r_owner;
  logic [WIDTH-1:0]  r_res;
  logic              r_zero;
  logic              w_winner;
  logic              w_grant0;
  logic              w_grant1;
  logic              w_accept;
  logic              w_rsp_take;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_winner = (req0_valid && req1_valid) ? 1'b0 : req1_valid;
`else
  logic r_last_grant;
  // On a tie the requester that did not win last time goes first.
  assign w_winner = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
`endif

  assign w_grant0   = (r_state == c_st_idle) && req0_valid && !w_winner;
  assign w_grant1   = (r_state == c_st_idle) && req1_valid &&  w_winner;
  assign w_accept   = w_grant0 || w_grant1;
  assign w_rsp_take = (r_state == c_st_resp) &&
                      (r_owner ? rsp1_ready : rsp0_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (w_accept) w_state_nxt = c_st_exec;
      c_st_exec: w_state_nxt = c_st_resp;
      c_st_resp: if (w_rsp_take) w_state_nxt = c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    req0_ready = w_grant0;
    req1_ready = w_grant1;
    rsp0_valid = (r_state == c_st_resp) && !r_owner;
    rsp1_valid = (r_state == c_st_resp) &&  r_owner;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lhs   <= '0;
      r_rhs   <= '0;
      r_func  <= '0;
      r_owner <= 1'b0;
      r_res   <= '0;
      r_zero  <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      r_last_grant <= 1'b1;
`endif
    end else begin
      if (w_accept) begin
        r_lhs   <= w_winner ? req1_lhs  : req0_lhs;
        r_rhs   <= w_winner ? req1_rhs  : req0_rhs;
        r_func  <= w_winner ? req1_func : req0_func;
        r_owner <= w_winner;
`ifndef ALU_ARB_FIXED_PRIO_EN
        r_last_grant <= w_winner;
`endif
      end
      if (r_state == c_st_exec) begin
        r_res  <= alu_res;
        r_zero <= alu_zero;
      end
    end
  end

  assign alu_lhs  = r_lhs;
  assign alu_rhs  = r_rhs;
  assign alu_func = 4'(r_func);

  // Only the owner's valid is asserted, so sharing the result regs is safe.
  assign rsp0_res  = r_res;
  assign rsp0_zero = r_zero;
  assign rsp1_res  = r_res;
  assign rsp1_zero = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// ============================================================================
// Module   : tb_alu_share_arbiter
// Brief    : Directed, table-driven bench for alu_share_arbiter with a small
//            behavioural ALU attached to the alu_* ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_lhs = '0, req0_rhs = '0, req1_lhs = '0, req1_rhs = '0;
  logic [2:0]  req0_func = '0, req1_func = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp0_res, rsp1_res;
  logic        rsp0_zero, rsp1_zero;
  logic [31:0] alu_lhs, alu_rhs, alu_res;
  logic [3:0]  alu_func;
  logic        alu_zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(32), .FUNC_W(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_lhs(req0_lhs),
    .req0_rhs(req0_rhs), .req0_func(req0_func),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_res(rsp0_res),
    .rsp0_zero(rsp0_zero),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_lhs(req1_lhs),
    .req1_rhs(req1_rhs), .req1_func(req1_func),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_res(rsp1_res),
    .rsp1_zero(rsp1_zero),
    .alu_lhs(alu_lhs), .alu_rhs(alu_rhs), .alu_func(alu_func),
    .alu_res(alu_res), .alu_zero(alu_zero)
  );

  // Reference ALU; unknown opcodes fall back to ADD.
  always_comb begin
    case (alu_func)
      4'd1:    alu_res = alu_lhs - alu_rhs;
      4'd2:    alu_res = alu_lhs & alu_rhs;
      4'd3:    alu_res = alu_lhs | alu_rhs;
      4'd4:    alu_res = alu_lhs ^ alu_rhs;
      4'd5:    alu_res = {31'd0, $signed(alu_lhs) < $signed(alu_rhs)};
      4'd6:    alu_res = {31'd0, alu_lhs < alu_rhs};
      default: alu_res = alu_lhs + alu_rhs;
    endcase
    alu_zero = (alu_res == 32'd0);
  end

  typedef struct {
    int          who;
    logic [2:0]  func;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [31:0] res;
    logic        zero;
    string       name;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic rdy(input int who);
    return (who == 1) ? req1_ready : req0_ready;
  endfunction

  function automatic logic rv(input int who);
    return (who == 1) ? rsp1_valid : rsp0_valid;
  endfunction

  task automatic set_req(input int who, input logic v, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b);
    if (who == 1) begin
      req1_valid = v; req1_func = f; req1_lhs = a; req1_rhs = b;
    end else begin
      req0_valid = v; req0_func = f; req0_lhs = a; req0_rhs = b;
    end
  endtask

  task automatic set_rsp_ready(input int who, input logic v);
    if (who == 1) rsp1_ready = v;
    else          rsp0_ready = v;
  endtask

  // Single transaction from one requester, checking the full 3-cycle timing.
  task automatic do_op(input int who, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic ez,
                       input string nm);
    int n;
    logic [31:0] got;
    @(negedge clk);
    set_req(who, 1'b1, f, a, b);
    #1;
    n = 0;
    while (!rdy(who) && n < 8) begin
      @(negedge clk); #1; n++;
    end
    chk({nm, "_ready"}, {31'd0, rdy(who)}, 32'd1);
    @(negedge clk);
    set_req(who, 1'b0, 3'd0, 32'd0, 32'd0);
    #1;
    chk({nm, "_exec_valid"}, {31'd0, rv(who)}, 32'd0);
    chk({nm, "_alu_func"}, {28'd0, alu_func}, {29'd0, f});
    chk({nm, "_alu_lhs"}, alu_lhs, a);
    @(negedge clk); #1;
    got = (who == 1) ? rsp1_res : rsp0_res;
    chk({nm, "_rsp_valid"}, {31'd0, rv(who)}, 32'd1);
    chk({nm, "_other_valid"}, {31'd0, rv(1 - who)}, 32'd0);
    chk({nm, "_res"}, got, er);
    chk({nm, "_zero"}, {31'd0, (who == 1) ? rsp1_zero : rsp0_zero}, {31'd0, ez});
    set_rsp_ready(who, 1'b1);
    @(negedge clk);
    set_rsp_ready(who, 1'b0);
    #1;
    chk({nm, "_rsp_done"}, {31'd0, rv(who)}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int w;
    int exp_w;
    logic [31:0] got;

    vecs[0] = '{0, 3'b000, 32'd5,          32'd7,      32'd12,     1'b0, "add_5_7"};
    vecs[1] = '{0, 3'b101, 32'hFFFF_FFFF, 32'd1,      32'd1,      1'b0, "slt_neg"};
    vecs[2] = '{0, 3'b110, 32'hFFFF_FFFF, 32'd1,      32'd0,      1'b1, "sltu_big"};
    vecs[3] = '{1, 3'b111, 32'd3,          32'd4,      32'd7,      1'b0, "op111_3_4"};
    vecs[4] = '{1, 3'b010, 32'h0000_F0F0, 32'h0FF0,   32'h00F0,   1'b0, "and"};
    vecs[5] = '{0, 3'b011, 32'h0000_1200, 32'h0034,   32'h1234,   1'b0, "or"};
    vecs[6] = '{1, 3'b100, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'd0,   1'b1, "xor_self"};
    vecs[7] = '{1, 3'b001, 32'd10,         32'd3,      32'd7,      1'b0, "sub_10_3"};

    // Reset state
    do_reset();
    #1;
    chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("rst_alu_lhs", alu_lhs, 32'd0);
    chk("rst_alu_rhs", alu_rhs, 32'd0);
    chk("rst_alu_func", {28'd0, alu_func}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].who, vecs[i].func, vecs[i].lhs, vecs[i].rhs,
            vecs[i].res, vecs[i].zero, vecs[i].name);
    end

    // Response backpressure with a competing request waiting
    @(negedge clk);
    set_req(1, 1'b1, 3'b001, 32'd9, 32'd9);
    #1;
    chk("bp_req1_ready", {31'd0, req1_ready}, 32'd1);
    @(negedge clk);
    set_req(1, 1'b0, 3'd0, 32'd0, 32'd0);
    set_req(0, 1'b1, 3'b000, 32'd2, 32'd3);
    #1;
    chk("bp_exec_req0_ready", {31'd0, req0_ready}, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
      chk("bp_rsp1_res", rsp1_res, 32'd0);
      chk("bp_rsp1_zero", {31'd0, rsp1_zero}, 32'd1);
      chk("bp_req0_ready", {31'd0, req0_ready}, 32'd0);
      @(negedge clk);
    end
    rsp1_ready = 1'b1;
    #1;
    chk("bp_take_req0_ready", {31'd0, req0_ready}, 32'd0);
    @(negedge clk);
    rsp1_ready = 1'b0;
    #1;
    chk("bp_idle_req0_ready", {31'd0, req0_ready}, 32'd1);
    chk("bp_idle_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    @(negedge clk);
    set_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
    @(negedge clk); #1;
    chk("bp_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("bp_rsp0_res", rsp0_res, 32'd5);
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;

    // Reset while in EXEC discards the transaction
    @(negedge clk);
    set_req(0, 1'b1, 3'b000, 32'd1, 32'd2);
    #1;
    chk("rx_req0_ready", {31'd0, req0_ready}, 32'd1);
    @(negedge clk);
    set_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rx_alu_lhs", alu_lhs, 32'd0);
    chk("rx_alu_func", {28'd0, alu_func}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("rx_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      @(negedge clk); #1;
    end
    do_op(0, 3'b000, 32'd20, 32'd22, 32'd42, 1'b0, "rx_after");

    // Both requesters valid continuously from reset
    do_reset();
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    set_req(0, 1'b1, 3'b011, 32'h0000_00F0, 32'h0000_000F);
    set_req(1, 1'b1, 3'b100, 32'h0000_00FF, 32'h0000_000F);
    for (int i = 0; i < 4; i++) begin
      #1;
      n = 0;
      while (!(req0_ready || req1_ready) && n < 8) begin
        @(negedge clk); #1; n++;
      end
      w = req1_ready ? 1 : 0;
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_w = 0;
`else
      exp_w = i % 2;
`endif
      chk("rr_grant", w, exp_w);
      @(negedge clk);
      @(negedge clk); #1;
      got = (w == 1) ? rsp1_res : rsp0_res;
      chk("rr_rsp_valid", {31'd0, rv(w)}, 32'd1);
      chk("rr_rsp_res", got, (w == 1) ? 32'h0000_00F0 : 32'h0000_00FF);
      @(negedge clk);
    end
    set_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
    set_req(1, 1'b0, 3'd0, 32'd0, 32'd0);
    @(negedge clk);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
